// File: rtl/pipeline_run_ctrl.sv
// Debug-unit run controller: streams program bytes into instruction memory, then gates the
// pipeline-latch enable for free-run or single-step. Optional watchdog: RUN_WATCHDOG_EN.
module pipeline_run_ctrl #(
    parameter int unsigned IMEM_DEPTH  = 64,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned WDOG_CYCLES = 4096
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    input  logic             i_byte_last,
    input  logic             i_halt_wb,
    output logic             o_pipe_en,
    output logic             o_imem_we,
    output logic [31:0]      o_imem_addr,
    output logic [31:0]      o_imem_data,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_load_err,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_cycle_cnt
);

    localparam int unsigned IdxW = $clog2(IMEM_DEPTH + 1);

    localparam logic [1:0] CmdStop = 2'b00;
    localparam logic [1:0] CmdStep = 2'b01;
    localparam logic [1:0] CmdRun  = 2'b10;
    localparam logic [1:0] CmdLoad = 2'b11;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StStep, StHalted} state_t;

    state_t            state_q, state_d;
    logic [IdxW-1:0]   idx_q;
    logic [1:0]        bcnt_q;
    logic [23:0]       word_q;      // earlier bytes of the word in progress, right-aligned
    logic              load_done_q;
    logic              pipe_en_q;
    logic              busy_q;
    logic              halted_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic              load_err_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              cmd_accept;
    logic              load_entry;
    logic              byte_take;
    logic              in_range;
    logic              word_full;
    logic [31:0]       shifted;
    logic [31:0]       aligned;
    logic [4:0]        pad_bits;
    logic              wdog_hit;

    assign o_cmd_ready = (state_q == StIdle) || (state_q == StHalted) || (state_q == StRun);
    assign cmd_accept  = i_cmd_valid && o_cmd_ready;

    assign byte_take = (state_q == StLoad) && i_byte_valid && !load_done_q;
    assign in_range  = idx_q < IdxW'(IMEM_DEPTH);
    assign word_full = (bcnt_q == 2'd3) || i_byte_last;
    assign shifted   = {word_q, i_byte};
    // A short final word is left-aligned: pad the unfilled low bytes with zero.
    assign pad_bits  = {2'd3 - bcnt_q, 3'b000};
    assign aligned   = shifted << pad_bits;

`ifdef RUN_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WDOG_CYCLES + 1);

    logic [WdW-1:0] wdog_q;
    logic           timeout_q;

    assign wdog_hit  = (state_q == StRun) && (wdog_q == WdW'(WDOG_CYCLES - 1));
    assign o_timeout = timeout_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            // Counts enabled RUN cycles; any non-RUN cycle clears it, so every RUN entry starts at 0.
            wdog_q <= (state_q == StRun) ? wdog_q + WdW'(1) : '0;
            if (load_entry) begin
                timeout_q <= 1'b0;
            end else if (wdog_hit && !i_halt_wb) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    logic unused_wdog;

    assign unused_wdog = ^WDOG_CYCLES;
    assign wdog_hit    = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StHalted: begin
                if (cmd_accept) begin
                    unique case (i_cmd)
                        CmdLoad: state_d = StLoad;
                        CmdRun:  if (state_q == StIdle) state_d = StRun;
                        CmdStep: if (state_q == StIdle) state_d = StStep;
                        default: state_d = state_q;
                    endcase
                end
            end
            StLoad: begin
                if (load_done_q) state_d = StIdle;
            end
            StRun: begin
                if (i_halt_wb || wdog_hit) begin
                    state_d = StHalted;
                end else if (cmd_accept && (i_cmd == CmdStop)) begin
                    state_d = StIdle;
                end
            end
            StStep: begin
                state_d = i_halt_wb ? StHalted : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign load_entry = (state_d == StLoad) && (state_q != StLoad);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= StIdle;
            pipe_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            idx_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            load_done_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            load_err_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q   <= state_d;
            pipe_en_q <= (state_d == StRun) || (state_d == StStep);
            busy_q    <= (state_d == StLoad) || (state_d == StRun) || (state_d == StStep);
            halted_q  <= (state_d == StHalted);
            we_q      <= 1'b0;

            if (load_entry) begin
                idx_q       <= '0;
                bcnt_q      <= '0;
                word_q      <= '0;
                load_done_q <= 1'b0;
                load_err_q  <= 1'b0;
            end else if (byte_take) begin
                if (in_range) begin
                    if (word_full) begin
                        we_q   <= 1'b1;
                        addr_q <= 32'(idx_q) << 2;
                        data_q <= aligned;
                        idx_q  <= idx_q + IdxW'(1);
                        bcnt_q <= '0;
                        word_q <= '0;
                    end else begin
                        word_q <= shifted[23:0];
                        bcnt_q <= bcnt_q + 2'd1;
                    end
                end else begin
                    load_err_q <= 1'b1;
                end
                if (i_byte_last) load_done_q <= 1'b1;
            end

            if (load_entry) begin
                cnt_q <= '0;
            end else if (pipe_en_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign o_pipe_en   = pipe_en_q;
    assign o_busy      = busy_q;
    assign o_halted    = halted_q;
    assign o_imem_we   = we_q;
    assign o_imem_addr = addr_q;
    assign o_imem_data = data_q;
    assign o_load_err  = load_err_q;
    assign o_cycle_cnt = cnt_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Bench for pipeline_run_ctrl: directed and randomized load/run/step sequences checked against
// a program-level model (word packing, enabled-cycle totals with saturation).
module tb_pipeline_run_ctrl;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned CW    = 6;
    localparam int unsigned WDOG  = 100;
    localparam int unsigned CMAX  = (1 << CW) - 1;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_cmd_valid = 1'b0;
    logic [1:0]    i_cmd = 2'b00;
    logic          o_cmd_ready;
    logic          i_byte_valid = 1'b0;
    logic [7:0]    i_byte = 8'h00;
    logic          i_byte_last = 1'b0;
    logic          i_halt_wb = 1'b0;
    logic          o_pipe_en;
    logic          o_imem_we;
    logic [31:0]   o_imem_addr;
    logic [31:0]   o_imem_data;
    logic          o_busy;
    logic          o_halted;
    logic          o_load_err;
    logic          o_timeout;
    logic [CW-1:0] o_cycle_cnt;

    pipeline_run_ctrl #(
        .IMEM_DEPTH  (DEPTH),
        .CNT_W       (CW),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cmd_valid  (i_cmd_valid),
        .i_cmd        (i_cmd),
        .o_cmd_ready  (o_cmd_ready),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .i_byte_last  (i_byte_last),
        .i_halt_wb    (i_halt_wb),
        .o_pipe_en    (o_pipe_en),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_data  (o_imem_data),
        .o_busy       (o_busy),
        .o_halted     (o_halted),
        .o_load_err   (o_load_err),
        .o_timeout    (o_timeout),
        .o_cycle_cnt  (o_cycle_cnt)
    );

    always #5 i_clk = ~i_clk;

    localparam logic [1:0] STOP = 2'b00, STEP = 2'b01, RUN = 2'b10, LOAD = 2'b11;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] wq[$];
    int          pe_cnt   = 0;
    int          model_cnt = 0;
    logic [7:0]  prog[$];

    // Every write-strobe cycle and every enabled cycle is logged mid-cycle.
    always @(negedge i_clk) begin
        if (o_imem_we) wq.push_back({o_imem_addr, o_imem_data});
        if (o_pipe_en) pe_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        i_cmd_valid = 1'b1;
        i_cmd       = c;
        tick();
        i_cmd_valid = 1'b0;
        i_cmd       = STOP;
    endtask

    function automatic int sat_cnt();
        return (model_cnt > int'(CMAX)) ? int'(CMAX) : model_cnt;
    endfunction

    task automatic gen_prog(input int n);
        prog.delete();
        repeat (n) prog.push_back(8'($urandom));
    endtask

    // Stream prog[] into the DUT and compare every write against a word-packing model.
    task automatic do_load(input int gap_max);
        int t, words, nw;
        logic [31:0] d;
        wq.delete();
        send_cmd(LOAD);
        model_cnt = 0;
        chk("load_ready", o_cmd_ready, 1'b0);
        foreach (prog[i]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) tick();
            i_byte_valid = 1'b1;
            i_byte       = prog[i];
            i_byte_last  = (i == prog.size() - 1);
            tick();
            i_byte_valid = 1'b0;
            i_byte_last  = 1'b0;
        end
        t = 0;
        while (o_busy && t < 20) begin
            tick();
            t++;
        end
        chk("load_busy_end", o_busy, 1'b0);
        words = (prog.size() + 3) / 4;
        nw    = (words > int'(DEPTH)) ? int'(DEPTH) : words;
        chk("load_nwrites", wq.size(), nw);
        for (int w = 0; w < nw && w < wq.size(); w++) begin
            d = '0;
            for (int b = 0; b < 4; b++)
                d = {d[23:0], (4 * w + b < prog.size()) ? prog[4 * w + b] : 8'h00};
            chk("load_word", wq[w], {32'(4 * w), d});
        end
        chk("load_err", o_load_err, words > int'(DEPTH));
        chk("load_cnt_clr", o_cycle_cnt, 0);
        chk("load_halted_clr", o_halted, 1'b0);
    endtask

    task automatic run_until_halt(input int n);
        int   pe0 = pe_cnt;
        logic ok  = 1'b1;
        send_cmd(RUN);
        for (int k = 1; k <= n; k++) begin
            ok &= (o_pipe_en === 1'b1);
            i_halt_wb = (k == n);
            tick();
        end
        i_halt_wb = 1'b0;
        model_cnt += n;
        chk("run_en_steady", ok, 1'b1);
        chk("run_en_cycles", pe_cnt - pe0, n);
        chk("run_halted", o_halted, 1'b1);
        chk("run_pipe_off", o_pipe_en, 1'b0);
        chk("run_cnt", o_cycle_cnt, sat_cnt());
    endtask

    initial begin
        int pe0, n, m, wsz;

        #2 i_rst = 1'b0;
        repeat (3) tick();
        chk("rst_pipe_en", o_pipe_en, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_halted", o_halted, 1'b0);
        chk("rst_outs", {o_imem_we, o_imem_addr, o_imem_data, o_load_err, o_timeout}, '0);
        chk("rst_cnt", o_cycle_cnt, 0);
        i_rst = 1'b1;
        tick();

        prog = '{8'h20, 8'h08, 8'h00, 8'h05};
        do_load(0);
        prog = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
        do_load(2);
        for (int r = 0; r < 4; r++) begin
            gen_prog($urandom_range(1, 23));
            do_load(3);
        end
        gen_prog(257 * 4);
        do_load(0);

        // Bytes outside LOAD must not produce writes.
        wsz = wq.size();
        i_byte_valid = 1'b1;
        i_byte_last  = 1'b1;
        tick();
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        tick();
        chk("idle_byte_ignored", wq.size(), wsz);

        gen_prog(8);
        do_load(0);
        run_until_halt(10);
        pe0 = pe_cnt;
        send_cmd(RUN);
        repeat (3) tick();
        send_cmd(STEP);
        repeat (2) tick();
        chk("halted_run_ignored", pe_cnt - pe0, 0);
        chk("halted_stays", o_halted, 1'b1);
        chk("halted_ready", o_cmd_ready, 1'b1);

        for (int r = 0; r < 3; r++) begin
            gen_prog($urandom_range(1, 12));
            do_load(1);
            run_until_halt($urandom_range(1, 40));
        end

        gen_prog(4);
        do_load(0);
        run_until_halt(70);

        // Isolated single steps, with a command presented during STEP that must be dropped.
        gen_prog(4);
        do_load(0);
        m   = $urandom_range(2, 5);
        pe0 = pe_cnt;
        for (int j = 0; j < m; j++) begin
            send_cmd(STEP);
            chk("step_ready", o_cmd_ready, 1'b0);
            chk("step_pipe_on", o_pipe_en, 1'b1);
            i_cmd_valid = 1'b1;
            i_cmd       = RUN;
            tick();
            i_cmd_valid = 1'b0;
            chk("step_pipe_off", o_pipe_en, 1'b0);
            repeat ($urandom_range(1, 3)) tick();
        end
        model_cnt += m;
        chk("step_pulses", pe_cnt - pe0, m);
        chk("step_cnt", o_cycle_cnt, sat_cnt());

        n   = $urandom_range(1, 20);
        pe0 = pe_cnt;
        send_cmd(RUN);
        chk("run_ready", o_cmd_ready, 1'b1);
        repeat (n - 1) tick();
        send_cmd(STOP);
        model_cnt += n;
        repeat (3) tick();
        chk("stop_en_cycles", pe_cnt - pe0, n);
        chk("stop_cnt_frozen", o_cycle_cnt, sat_cnt());
        chk("stop_idle", {o_busy, o_halted}, 2'b00);

        send_cmd(RUN);
        tick();
        i_halt_wb   = 1'b1;
        i_cmd_valid = 1'b1;
        i_cmd       = STOP;
        tick();
        i_halt_wb   = 1'b0;
        i_cmd_valid = 1'b0;
        model_cnt += 2;
        chk("halt_beats_stop", o_halted, 1'b1);
        chk("halt_stop_cnt", o_cycle_cnt, sat_cnt());

        gen_prog(2);
        do_load(0);
        send_cmd(STEP);
        i_halt_wb = 1'b1;
        tick();
        i_halt_wb = 1'b0;
        chk("step_halt", o_halted, 1'b1);
        chk("step_halt_cnt", o_cycle_cnt, 1);
        chk("no_timeout", o_timeout, 1'b0);

`ifdef RUN_WATCHDOG_EN
        gen_prog(4);
        do_load(0);
        pe0 = pe_cnt;
        send_cmd(RUN);
        n = 0;
        while (!o_halted && n < int'(WDOG) + 20) begin
            tick();
            n++;
        end
        chk("wdog_en_cycles", pe_cnt - pe0, WDOG);
        chk("wdog_timeout", o_timeout, 1'b1);
        chk("wdog_halted", o_halted, 1'b1);
        gen_prog(4);
        do_load(0);
        chk("wdog_load_clr", o_timeout, 1'b0);
        run_until_halt(WDOG);
        chk("wdog_halt_wins", o_timeout, 1'b0);
`endif

        // Reset in the middle of a word and in the middle of a run.
        wsz = wq.size();
        send_cmd(LOAD);
        i_byte_valid = 1'b1;
        repeat (2) tick();
        i_byte_valid = 1'b0;
        i_rst = 1'b0;
        #1;
        chk("rst_load_busy", o_busy, 1'b0);
        repeat (2) tick();
        i_rst = 1'b1;
        repeat (3) tick();
        chk("rst_load_nowrite", wq.size(), wsz);
        send_cmd(RUN);
        repeat (4) tick();
        i_rst = 1'b0;
        #1;
        chk("rst_run_outs", {o_pipe_en, o_busy, o_halted, o_load_err, o_timeout, o_imem_we}, '0);
        chk("rst_run_cnt", o_cycle_cnt, 0);
        tick();
        i_rst = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
